// File: rtl/micro_sequencer.sv
// Microprogram sequencer: writable control store, MPC and MIR, with
// JAMN/JAMZ/JMPC next-address logic plus stall, halt and abort control.
module micro_sequencer #(
  parameter  int ADDR_W     = 9,
  parameter  int DATA_W     = 32,
  parameter  int MBR_W      = 8,
  parameter  int ALU_W      = 6,
  parameter  int C_W        = 9,
  parameter  int B_W        = 4,
  parameter  int START_ADDR = 1,
  localparam int CW_W       = ADDR_W + 3 + ALU_W + 2 + C_W + B_W + 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              stall,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [MBR_W-1:0]  mbr,
  input  logic              cs_we,
  input  logic [ADDR_W-1:0] cs_waddr,
  input  logic [CW_W-1:0]   cs_wdata,
  output logic [ADDR_W-1:0] mpc,
  output logic [ALU_W-1:0]  alu_opcode,
  output logic [1:0]        shifter_opcode,
  output logic [C_W-1:0]    c_select,
  output logic [B_W-1:0]    b_select,
  output logic [2:0]        jam,
  output logic [2:0]        m,
  output logic              n_flag,
  output logic              z_flag,
  output logic              running,
  output logic              halted,
  output logic [15:0]       step_count
);

  localparam int DEPTH  = 2**ADDR_W;
  localparam int M_LO   = 0;
  localparam int B_LO   = M_LO + 3;
  localparam int C_LO   = B_LO + B_W;
  localparam int SH_LO  = C_LO + C_W;
  localparam int ALU_LO = SH_LO + 2;
  localparam int JAM_LO = ALU_LO + ALU_W;
  localparam int NA_LO  = JAM_LO + 3;
  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL, S_HALT} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   mpc_q;
  logic [CW_W-1:0]     mir_q;
  logic                n_q, z_q;
  logic [15:0]         cnt_q;
  logic [CW_W-1:0]     cs_q [DEPTH];

  logic [ADDR_W-1:0]   na_f;
  logic [2:0]          jam_f;
  logic [ALU_W-1:0]    alu_f;
  logic [1:0]          sh_f;
  logic [C_W-1:0]      c_f;
  logic [B_W-1:0]      b_f;
  logic [2:0]          m_f;

  assign na_f  = mir_q[NA_LO  +: ADDR_W];
  assign jam_f = mir_q[JAM_LO +: 3];
  assign alu_f = mir_q[ALU_LO +: ALU_W];
  assign sh_f  = mir_q[SH_LO  +: 2];
  assign c_f   = mir_q[C_LO   +: C_W];
  assign b_f   = mir_q[B_LO   +: B_W];
  assign m_f   = mir_q[M_LO   +: 3];

  logic              n_d, z_d, branch_d, halt_d, idle_like, cs_wr;
  logic [ADDR_W-1:0] next_d;

  // Next address is an OR of the three sources, never an add.
  assign n_d       = alu_result[DATA_W-1];
  assign z_d       = (alu_result == '0);
  assign branch_d  = (jam_f[1] & n_d) | (jam_f[0] & z_d);
  assign next_d    = na_f
                   | {branch_d, {(ADDR_W-1){1'b0}}}
                   | (jam_f[2] ? ADDR_W'(mbr) : '0);
  assign halt_d    = (jam_f == 3'b000) && (na_f == mpc_q);
  assign idle_like = (state_q == S_IDLE) || (state_q == S_HALT);
  assign cs_wr     = cs_we && idle_like && !start;

  always_ff @(posedge clock) begin
    if (cs_wr) cs_q[cs_waddr] <= cs_wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mpc_q   <= '0;
      mir_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      cnt_q   <= '0;
    end else if (abort) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            state_q <= S_RUN;
            mpc_q   <= START_A;
            mir_q   <= cs_q[START_A];
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            cnt_q   <= '0;
          end
        end
        S_RUN, S_STALL: begin
          if (stall) begin
            state_q <= S_STALL;
          end else begin
            // The halting word still counts and still loads its successor.
            state_q <= halt_d ? S_HALT : S_RUN;
            mpc_q   <= next_d;
            mir_q   <= cs_q[next_d];
            n_q     <= n_d;
            z_q     <= z_d;
            if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    alu_opcode     = '0;
    shifter_opcode = '0;
    c_select       = '0;
    b_select       = '0;
    jam            = '0;
    m              = '0;
    if (state_q == S_RUN || state_q == S_STALL) begin
      alu_opcode     = alu_f;
      shifter_opcode = sh_f;
      b_select       = b_f;
      jam            = jam_f;
    end
    // Writes and memory strobes are suppressed while stalled.
    if (state_q == S_RUN) begin
      c_select = c_f;
      m        = m_f;
    end
  end

  assign mpc        = mpc_q;
  assign n_flag     = n_q;
  assign z_flag     = z_q;
  assign running    = (state_q == S_RUN) || (state_q == S_STALL);
  assign halted     = (state_q == S_HALT);
  assign step_count = cnt_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Randomized bench for micro_sequencer against a field-level behavioural
// model, plus directed microprograms for branching, stall, halt and abort.
module tb_micro_sequencer;
  localparam int ADDR_W = 9, DATA_W = 32, MBR_W = 8, ALU_W = 6;
  localparam int C_W = 9, B_W = 4, START_ADDR = 1;
  localparam int CW_W  = ADDR_W + 3 + ALU_W + 2 + C_W + B_W + 3;
  localparam int DEPTH = 2**ADDR_W;
  localparam int M_IDLE = 0, M_RUN = 1, M_STALL = 2, M_HALT = 3;

  logic              clock, reset_n, start, abort, stall, cs_we;
  logic [DATA_W-1:0] alu_result;
  logic [MBR_W-1:0]  mbr;
  logic [ADDR_W-1:0] cs_waddr, mpc;
  logic [CW_W-1:0]   cs_wdata;
  logic [ALU_W-1:0]  alu_opcode;
  logic [1:0]        shifter_opcode;
  logic [C_W-1:0]    c_select;
  logic [B_W-1:0]    b_select;
  logic [2:0]        jam, m;
  logic              n_flag, z_flag, running, halted;
  logic [15:0]       step_count;

  micro_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MBR_W(MBR_W), .ALU_W(ALU_W),
                    .C_W(C_W), .B_W(B_W), .START_ADDR(START_ADDR)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort), .stall(stall),
    .alu_result(alu_result), .mbr(mbr), .cs_we(cs_we), .cs_waddr(cs_waddr),
    .cs_wdata(cs_wdata), .mpc(mpc), .alu_opcode(alu_opcode),
    .shifter_opcode(shifter_opcode), .c_select(c_select), .b_select(b_select),
    .jam(jam), .m(m), .n_flag(n_flag), .z_flag(z_flag), .running(running),
    .halted(halted), .step_count(step_count));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { int na; int jmp; int alu; int sh; int c; int b; int mm; } uw_t;

  uw_t mcs [DEPTH];
  uw_t m_mir, wr_word;
  int  m_st, m_mpc, m_n, m_z, m_cnt;
  int  n_chk, n_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CW_W-1:0] pack(input uw_t w);
    return {ADDR_W'(w.na), 3'(w.jmp), ALU_W'(w.alu), 2'(w.sh), C_W'(w.c), B_W'(w.b), 3'(w.mm)};
  endfunction

  function automatic uw_t zw();
    uw_t w = '{na:0, jmp:0, alu:0, sh:0, c:0, b:0, mm:0};
    return w;
  endfunction

  function automatic uw_t rand_word(input int addr);
    uw_t w;
    w.na  = $urandom_range(0, DEPTH-1);
    w.jmp = $urandom_range(0, 7);
    w.alu = $urandom_range(0, (1<<ALU_W)-1);
    w.sh  = $urandom_range(0, 3);
    w.c   = $urandom_range(0, (1<<C_W)-1);
    w.b   = $urandom_range(0, (1<<B_W)-1);
    w.mm  = $urandom_range(0, 7);
    if ($urandom_range(0, 7) == 0) begin w.na = addr; w.jmp = 0; end
    return w;
  endfunction

  function automatic void model_reset();
    m_st = M_IDLE; m_mpc = 0; m_mir = zw(); m_n = 0; m_z = 0; m_cnt = 0;
  endfunction

  function automatic void model_step();
    bit idle_like = (m_st == M_IDLE) || (m_st == M_HALT);
    bit do_wr = cs_we && idle_like && !start;
    bit nn, zz;
    int nxt;
    uw_t w = m_mir;
    if (abort) m_st = M_IDLE;
    else if (idle_like) begin
      if (start) begin
        m_st = M_RUN; m_mpc = START_ADDR; m_mir = mcs[START_ADDR];
        m_n = 0; m_z = 0; m_cnt = 0;
      end
    end else if (stall) m_st = M_STALL;
    else begin
      nn  = alu_result[DATA_W-1];
      zz  = (alu_result == 0);
      nxt = w.na;
      if (((w.jmp & 2) != 0 && nn) || ((w.jmp & 1) != 0 && zz)) nxt = nxt | (1 << (ADDR_W-1));
      if ((w.jmp & 4) != 0) nxt = nxt | int'(mbr);
      m_st  = (w.jmp == 0 && w.na == m_mpc) ? M_HALT : M_RUN;
      m_mpc = nxt; m_mir = mcs[nxt]; m_n = nn; m_z = zz;
      if (m_cnt < 65535) m_cnt++;
    end
    if (do_wr) mcs[cs_waddr] = wr_word;
  endfunction

  task automatic check_outs();
    uw_t e = zw();
    logic [63:0] exp_ctrl;
    if (m_st == M_RUN) e = m_mir;
    else if (m_st == M_STALL) begin
      e = m_mir; e.c = 0; e.mm = 0; e.na = 0;
    end
    exp_ctrl = {ALU_W'(e.alu), 2'(e.sh), C_W'(e.c), B_W'(e.b), 3'(e.jmp), 3'(e.mm)};
    chk("mpc", mpc, m_mpc);
    chk("ctrl", {alu_opcode, shifter_opcode, c_select, b_select, jam, m}, exp_ctrl);
    chk("flags", {n_flag, z_flag, running, halted},
        m_n*8 + m_z*4 + ((m_st == M_RUN || m_st == M_STALL) ? 2 : 0) + ((m_st == M_HALT) ? 1 : 0));
    chk("step_count", step_count, m_cnt);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check_outs();
  endtask

  task automatic cs_write(input int a, input uw_t w);
    cs_we = 1'b1; cs_waddr = ADDR_W'(a); wr_word = w; cs_wdata = pack(w);
    tick();
    cs_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  // Start at 1 (which jumps to 5), then advance once from 5 with the given ALU value.
  task automatic run_from5(input logic [DATA_W-1:0] res);
    pulse_start();
    tick();
    alu_result = res;
    tick();
  endtask

  uw_t w;
  int  pm, pc;

  initial begin
    n_chk = 0; n_err = 0;
    reset_n = 1'b1; start = 0; abort = 0; stall = 0; cs_we = 0;
    alu_result = '0; mbr = '0; cs_waddr = '0; cs_wdata = '0; wr_word = zw();
    for (int i = 0; i < DEPTH; i++) mcs[i] = zw();
    #1 reset_n = 1'b0;
    #2;
    model_reset();
    check_outs();
    @(negedge clock) reset_n = 1'b1;

    for (int a = 0; a < DEPTH; a++) cs_write(a, rand_word(a));

    // Two-word program ending in a self-loop halt.
    w = zw(); w.na = 2; w.alu = 'b110001; w.c = 'b010000000;
    cs_write(1, w);
    w = zw(); w.na = 2;
    cs_write(2, w);
    pulse_start();
    chk("tp_mpc1", mpc, 1);
    chk("tp_alu", alu_opcode, 6'b110001);
    chk("tp_csel", c_select, 9'b010000000);
    tick();
    chk("tp_mpc2", mpc, 2);
    tick();
    chk("tp_halted", halted, 1);
    chk("tp_ctrl0", {alu_opcode, shifter_opcode, c_select, b_select, jam, m}, 0);
    chk("tp_cnt", step_count, 2);

    w = zw(); w.na = 5;
    cs_write(1, w);
    w = zw(); w.na = 6; w.jmp = 1;
    cs_write(5, w);
    run_from5(32'd0);
    chk("jamz_mpc", mpc, 9'h106);
    chk("jamz_z", z_flag, 1);
    pulse_abort();
    run_from5(32'd7);
    chk("jamz_nt_mpc", mpc, 9'h006);
    chk("jamz_nt_z", z_flag, 0);

    pulse_abort();
    w = zw(); w.na = 6; w.jmp = 2;
    cs_write(5, w);
    run_from5(32'h8000_0000);
    chk("jamn_mpc", mpc, 9'h106);
    chk("jamn_n", n_flag, 1);

    pulse_abort();
    w = zw(); w.na = 9'h100; w.jmp = 4;
    cs_write(5, w);
    mbr = 8'h3C;
    run_from5(32'd5);
    chk("jmpc_mpc", mpc, 9'h13C);

    // 1 <-> 3 loop with live c_select/m to observe stall masking.
    pulse_abort();
    w = '{na:3, jmp:0, alu:5, sh:1, c:'h1FF, b:3, mm:7};
    cs_write(1, w);
    w.na = 1;
    cs_write(3, w);
    pulse_start();
    pm = mpc; pc = step_count;
    stall = 1'b1;
    repeat (3) begin
      tick();
      chk("stall_mpc", mpc, pm);
      chk("stall_cnt", step_count, pc);
      chk("stall_c_m", {c_select, m}, 0);
      chk("stall_alu", alu_opcode, 5);
    end
    stall = 1'b0;
    tick();
    chk("unstall_mpc", mpc, 3);

    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outs();
    chk("arst_mpc", mpc, 0);
    chk("arst_run", running, 0);
    @(negedge clock) reset_n = 1'b1;

    pulse_start();
    tick(); tick();
    pulse_abort();
    chk("abort_cnt", step_count, 2);
    chk("abort_run", running, 0);

    pulse_start();
    w = '{na:3, jmp:0, alu:'h2A, sh:0, c:0, b:0, mm:0};
    cs_write(1, w);
    pulse_abort();
    pulse_start();
    chk("wr_drop_alu", alu_opcode, 5);

    for (int i = 0; i < 600; i++) begin
      start  = ($urandom_range(0, 7) == 0);
      abort  = ($urandom_range(0, 31) == 0);
      stall  = ($urandom_range(0, 3) == 0);
      mbr    = MBR_W'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0: alu_result = '0;
        1: alu_result = 32'h8000_0000 | $urandom;
        default: alu_result = $urandom;
      endcase
      cs_we    = ($urandom_range(0, 5) == 0);
      cs_waddr = ADDR_W'($urandom_range(0, DEPTH-1));
      wr_word  = rand_word(int'(cs_waddr));
      cs_wdata = pack(wr_word);
      tick();
    end
    start = 0; abort = 0; stall = 0; cs_we = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
